// File: rtl/sevenseg_mux_driver_if.sv
// Datapath-facing bundle of the seven-segment scanner: display data and
// controls in, registered pin drives out.
interface sevenseg_mux_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lzb_en;
  logic [3:0]              brightness;
  logic [6:0]              seg;
  logic                    seg_dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, dp, load, digit_en, lzb_en, brightness,
    input  seg, seg_dp, an, frame_done
  );

  modport slave (
    input  value, dp, load, digit_en, lzb_en, brightness,
    output seg, seg_dp, an, frame_done
  );
endinterface

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed N-digit seven-segment scanner with prescaled refresh,
// frame-aligned (tear-free) data load, leading-zero blanking and 16-step PWM.
module sevenseg_mux_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sevenseg_mux_driver_if.slave bus
);

  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned CNT_MAX = PRESCALE / 16 - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [3:0]            phase_q,      phase_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic                  frame_done_q, frame_done_d;
  logic [VAL_W-1:0]      stg_val_q,    stg_val_d;
  logic [NUM_DIGITS-1:0] stg_dp_q,     stg_dp_d;
  logic [VAL_W-1:0]      disp_val_q,   disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
  logic [6:0]            seg_q,        seg_d;
  logic                  seg_dp_q,     seg_dp_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;

  logic                  cnt_tc;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  dig_dp;
  logic                  dig_en;
  logic                  lz_run;
  logic                  lz_blank;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan timing, staging capture and frame-boundary display update.
  always_comb begin
    cnt_tc   = (cnt_q == CNT_W'(CNT_MAX));
    slot_end = cnt_tc && (phase_q == 4'hF);
    wrap     = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    cnt_d   = cnt_tc ? '0 : cnt_q + CNT_W'(1);
    phase_d = cnt_tc ? phase_q + 4'd1 : phase_q;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    frame_done_d = wrap;

    stg_val_d = bus.load ? bus.value : stg_val_q;
    stg_dp_d  = bus.load ? bus.dp    : stg_dp_q;
    // Display regs sample the pre-edge staging, so a load on the wrap cycle waits a frame.
    disp_val_d = wrap ? stg_val_q : disp_val_q;
    disp_dp_d  = wrap ? stg_dp_q  : disp_dp_q;
  end

  // Select the current digit; lz_run stays set while every digit so far is zero.
  always_comb begin
    nib      = 4'h0;
    dig_dp   = 1'b0;
    dig_en   = 1'b0;
    lz_blank = 1'b0;
    an_sel   = '0;
    lz_run   = bus.lzb_en;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      lz_run = lz_run && (disp_val_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib       = disp_val_q[4*(NUM_DIGITS-1-i) +: 4];
        dig_dp    = disp_dp_q[NUM_DIGITS-1-i];
        dig_en    = bus.digit_en[NUM_DIGITS-1-i];
        lz_blank  = lz_run && (i < int'(NUM_DIGITS) - 1);
        an_sel[i] = 1'b1;
      end
    end
  end

  // Pin values: PWM gate on the anode, segments dark whenever the anode is off.
  always_comb begin
    lit      = dig_en && (phase_q <= bus.brightness);
    an_d     = AN_OFF  ^ (lit ? an_sel : '0);
    seg_d    = SEG_OFF ^ ((lit && !lz_blank) ? hex7(nib) : 7'h00);
    seg_dp_d = ACTIVE_LOW ^ (lit && dig_dp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      phase_q      <= 4'h0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      seg_dp_q     <= ACTIVE_LOW;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench for sevenseg_mux_driver: 4-digit active-low and 8-digit
// active-high instances at one cycle per PWM phase.
module tb_sevenseg_mux_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sevenseg_mux_driver_if #(.NUM_DIGITS(4)) bus4 ();
  sevenseg_mux_driver_if #(.NUM_DIGITS(8)) bus8 ();

  sevenseg_mux_driver #(.NUM_DIGITS(4), .PRESCALE(16), .ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  sevenseg_mux_driver #(.NUM_DIGITS(8), .PRESCALE(16), .ACTIVE_LOW(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'h3F;  4'h1: dec7 = 7'h06;  4'h2: dec7 = 7'h5B;  4'h3: dec7 = 7'h4F;
      4'h4: dec7 = 7'h66;  4'h5: dec7 = 7'h6D;  4'h6: dec7 = 7'h7D;  4'h7: dec7 = 7'h07;
      4'h8: dec7 = 7'h7F;  4'h9: dec7 = 7'h6F;  4'hA: dec7 = 7'h77;  4'hB: dec7 = 7'h7C;
      4'hC: dec7 = 7'h39;  4'hD: dec7 = 7'h5E;  4'hE: dec7 = 7'h79;  default: dec7 = 7'h71;
    endcase
  endfunction

  // Called at a falling edge; the value is captured on the next rising edge.
  task automatic load4(input logic [15:0] v, input logic [3:0] d);
    bus4.value = v;
    bus4.dp    = d;
    bus4.load  = 1'b1;
    @(negedge clk);
    bus4.load  = 1'b0;
  endtask

  // Returns at the falling edge where frame_done is seen; the next 64 falling edges form one frame.
  task automatic wait_frame4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus4.frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus4.value = '0; bus4.dp = '0; bus4.load = 1'b0; bus4.digit_en = 4'hF;
    bus4.lzb_en = 1'b0; bus4.brightness = 4'hF;
    bus8.value = '0; bus8.dp = '0; bus8.load = 1'b0; bus8.digit_en = 8'hFF;
    bus8.lzb_en = 1'b0; bus8.brightness = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus4.an !== 4'hF) begin n_err++; $display("FAIL reset_an4: got %b want 1111", bus4.an); end
    n_vec++; if (bus4.seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg4: got %h want 7f", bus4.seg); end
    n_vec++; if (bus4.seg_dp !== 1'b1) begin n_err++; $display("FAIL reset_dp4: got %b want 1", bus4.seg_dp); end
    n_vec++; if (bus4.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd4: got %b want 0", bus4.frame_done); end
    n_vec++; if (bus8.an !== 8'h00) begin n_err++; $display("FAIL reset_an8: got %b want 00000000", bus8.an); end
    n_vec++; if (bus8.seg !== 7'h00) begin n_err++; $display("FAIL reset_seg8: got %h want 00", bus8.seg); end
    n_vec++; if (bus8.seg_dp !== 1'b0) begin n_err++; $display("FAIL reset_dp8: got %b want 0", bus8.seg_dp); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    bit ok;
    int d;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    bus4.digit_en = 4'hF; bus4.lzb_en = 1'b0; bus4.brightness = 4'hF;
    load4(16'h0D8C, 4'b0000);
    wait_frame4(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_sync: frame_done got none want pulse"); end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      d = k / 16;
      exp_an = ~(4'b0001 << d);
      case (d)
        0:       exp_seg = 7'h40;
        1:       exp_seg = 7'h21;
        2:       exp_seg = 7'h00;
        default: exp_seg = 7'h46;
      endcase
      n_vec++; if (bus4.an !== exp_an) begin n_err++; $display("FAIL basic_an k=%0d: got %b want %b", k, bus4.an, exp_an); end
      n_vec++; if (bus4.seg !== exp_seg) begin n_err++; $display("FAIL basic_seg k=%0d: got %h want %h", k, bus4.seg, exp_seg); end
      n_vec++; if (bus4.seg_dp !== 1'b1) begin n_err++; $display("FAIL basic_dp k=%0d: got %b want 1", k, bus4.seg_dp); end
      n_vec++; if (bus4.frame_done !== (k == 63)) begin n_err++; $display("FAIL basic_fd k=%0d: got %b want %b", k, bus4.frame_done, (k == 63)); end
    end
  endtask

  task automatic test_lz_blank();
    bit ok;
    int d;
    logic [6:0] exp_seg;
    logic       exp_dp;
    bus4.lzb_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) load4(16'h0040, 4'b0000);
      else           load4(16'h0000, 4'b1000);
      wait_frame4(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL lz_sync pass=%0d: frame_done got none want pulse", pass); end
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        d = k / 16;
        if (pass == 0) exp_seg = (d < 2) ? 7'h7F : (d == 2) ? 7'h19 : 7'h40;
        else           exp_seg = (d < 3) ? 7'h7F : 7'h40;
        exp_dp = !(pass == 1 && d == 0);
        n_vec++; if (bus4.an !== ~(4'b0001 << d)) begin n_err++; $display("FAIL lz_an pass=%0d k=%0d: got %b", pass, k, bus4.an); end
        n_vec++; if (bus4.seg !== exp_seg) begin n_err++; $display("FAIL lz_seg pass=%0d k=%0d: got %h want %h", pass, k, bus4.seg, exp_seg); end
        n_vec++; if (bus4.seg_dp !== exp_dp) begin n_err++; $display("FAIL lz_dp pass=%0d k=%0d: got %b want %b", pass, k, bus4.seg_dp, exp_dp); end
      end
    end
    bus4.lzb_en = 1'b0;
  endtask

  task automatic test_pwm_enable();
    bit ok;
    int d, p;
    bit lit;
    int low_cnt [4];
    int exp_low [4];
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    segs    = '{7'h79, 7'h24, 7'h30, 7'h19};
    exp_low = '{4, 0, 4, 4};
    low_cnt = '{0, 0, 0, 0};
    bus4.brightness = 4'd3; bus4.digit_en = 4'b1011;
    load4(16'h1234, 4'b0000);
    wait_frame4(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pwm_sync: frame_done got none want pulse"); end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      d = k / 16; p = k % 16;
      lit = (d != 1) && (p <= 3);
      exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit ? segs[d] : 7'h7F;
      for (int j = 0; j < 4; j++) if (bus4.an[j] === 1'b0) low_cnt[j]++;
      n_vec++; if (bus4.an !== exp_an) begin n_err++; $display("FAIL pwm_an k=%0d: got %b want %b", k, bus4.an, exp_an); end
      n_vec++; if (bus4.seg !== exp_seg) begin n_err++; $display("FAIL pwm_seg k=%0d: got %h want %h", k, bus4.seg, exp_seg); end
      n_vec++; if ($countones(~bus4.an) > 1) begin n_err++; $display("FAIL pwm_onehot k=%0d: got %b want at most one low", k, bus4.an); end
    end
    for (int j = 0; j < 4; j++) begin
      n_vec++; if (low_cnt[j] != exp_low[j]) begin n_err++; $display("FAIL pwm_duty an[%0d]: got %0d want %0d", j, low_cnt[j], exp_low[j]); end
    end
    bus4.brightness = 4'hF; bus4.digit_en = 4'hF;
  endtask

  task automatic test_tear_free();
    bit ok;
    int d;
    logic [15:0] frame_val [4];
    logic [15:0] v;
    logic [6:0]  exp_seg;
    frame_val = '{16'h1234, 16'hABCD, 16'hABCD, 16'h5678};
    wait_frame4(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL tear_sync: frame_done got none want pulse"); end
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        d = k / 16;
        v = frame_val[f];
        exp_seg = ~dec7(v[15-4*d -: 4]);
        n_vec++; if (bus4.seg !== exp_seg) begin n_err++; $display("FAIL tear_seg f=%0d k=%0d: got %h want %h", f, k, bus4.seg, exp_seg); end
        n_vec++; if (bus4.frame_done !== (k == 63)) begin n_err++; $display("FAIL tear_fd f=%0d k=%0d: got %b", f, k, bus4.frame_done); end
        bus4.load = 1'b0;
        if (f == 0 && k == 20) begin bus4.value = 16'h9999; bus4.load = 1'b1; end
        if (f == 0 && k == 40) begin bus4.value = 16'hABCD; bus4.load = 1'b1; end
        if (f == 1 && k == 62) begin bus4.value = 16'h5678; bus4.load = 1'b1; end
      end
    end
    bus4.load = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    wait_frame4(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_sync: frame_done got none want pulse"); end
    repeat (40) @(negedge clk);
    n_vec++; if (bus4.an !== 4'b1011) begin n_err++; $display("FAIL rstmid_pre_an: got %b want 1011", bus4.an); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus4.an !== 4'hF) begin n_err++; $display("FAIL rstmid_an: got %b want 1111", bus4.an); end
    n_vec++; if (bus4.seg !== 7'h7F) begin n_err++; $display("FAIL rstmid_seg: got %h want 7f", bus4.seg); end
    n_vec++; if (bus4.seg_dp !== 1'b1) begin n_err++; $display("FAIL rstmid_dp: got %b want 1", bus4.seg_dp); end
    n_vec++; if (bus4.frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_fd: got %b want 0", bus4.frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_vec++; if (bus4.an !== ~(4'b0001 << (k / 16))) begin n_err++; $display("FAIL rstmid_scan_an k=%0d: got %b", k, bus4.an); end
      n_vec++; if (bus4.seg !== 7'h40) begin n_err++; $display("FAIL rstmid_scan_seg k=%0d: got %h want 40", k, bus4.seg); end
      n_vec++; if (bus4.frame_done !== (k == 63)) begin n_err++; $display("FAIL rstmid_scan_fd k=%0d: got %b", k, bus4.frame_done); end
    end
  endtask

  task automatic test_param_sweep();
    bit ok;
    int d;
    logic [6:0] segs [8];
    logic [7:0] exp_an;
    segs = '{7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bus8.value = 32'h89AB_CDEF; bus8.dp = 8'b1000_0001; bus8.load = 1'b1;
    @(negedge clk);
    bus8.load = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus8.frame_done === 1'b1) ok = 1'b1;
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL p8_sync: frame_done got none want pulse"); end
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      d = k / 16;
      exp_an = 8'b0000_0001 << d;
      n_vec++; if (bus8.an !== exp_an) begin n_err++; $display("FAIL p8_an k=%0d: got %b want %b", k, bus8.an, exp_an); end
      n_vec++; if (bus8.seg !== segs[d]) begin n_err++; $display("FAIL p8_seg k=%0d: got %h want %h", k, bus8.seg, segs[d]); end
      n_vec++; if (bus8.seg_dp !== (d == 0 || d == 7)) begin n_err++; $display("FAIL p8_dp k=%0d: got %b", k, bus8.seg_dp); end
      n_vec++; if (bus8.frame_done !== (k == 127)) begin n_err++; $display("FAIL p8_fd k=%0d: got %b", k, bus8.frame_done); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_pwm_enable();
    test_tear_free();
    test_reset_mid_scan();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
